reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Read-side companion to the register file. On a start request it walks a
//  contiguous index range of the register file outputs and streams each word
//  out over a valid/ready handshake, one word per cycle when not stalled.
//  It ends each dump with a done pulse and a modular checksum.
//  It sits beside the register file and feeds the debug/trace path for the
//  single-cycle core benches and the UART dump.
// PARAMETERS
//  DATA_WIDTH  32  width of each register word
//  ADDR_WIDTH  5   index width; NUM_REGS = 2**ADDR_WIDTH
//  ZERO_R0     1   1: index 0 always streams as 0, regardless of regs_flat
// PORTS
//  clk        in   1                     single clock, rising edge
//  rst        in   1                     reset: synchronous, active-low
//  start      in   1                     request a dump; sampled only in IDLE
//  start_idx  in   ADDR_WIDTH            first index, latched with start
//  end_idx    in   ADDR_WIDTH            last index (inclusive), latched with start
//  abort      in   1                     cancel the dump in progress
//  regs_flat  in   NUM_REGS*DATA_WIDTH   Q0 in bits [DW-1:0], Q1 next, ... (live reg outputs)
//  out_valid  out  1                     out_data/out_idx valid
//  out_ready  in   1                     consumer accepts the word when valid&ready
//  out_data   out  DATA_WIDTH            register word
//  out_idx    out  ADDR_WIDTH            index of out_data
//  out_last   out  1                     current word is end_idx
//  busy       out  1                     high whenever state != IDLE
//  done       out  1                     1-cycle pulse after last word accepted
//  checksum   out  DATA_WIDTH            sum of accepted words mod 2**DW; stable from done to next start
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; all outputs 0; latched indices 0.
//    Applies at any time, including mid-dump; the partial dump is discarded.
//  States: IDLE, SEND. (The done pulse is registered and issued on the return to IDLE.)
//  IDLE, start=1, start_idx<=end_idx:
//    next cycle: state=SEND, busy=1, out_valid=1, out_idx=start_idx;
//    out_data = regs_flat word sampled at the start edge; checksum cleared to 0.
//  IDLE, start=1, start_idx>end_idx:
//    no word streamed; done=1 for exactly 1 cycle; checksum=0; stays IDLE.
//  SEND, out_valid&out_ready (transfer):
//    checksum += out_data (wraps modulo 2**DW).
//    If out_idx!=end_idx: next cycle out_idx+1, out_data = new sample,
//      out_valid stays 1, so back-to-back transfers occur.
//    If out_idx==end_idx: next cycle out_valid=0, busy=0, done=1 for 1 cycle, IDLE.
//  SEND, out_valid&!out_ready (stall):
//    out_data, out_idx and out_last are held bit-stable. Live register changes
//    are not reflected in the held word.
//  Sampling: a word is sampled from regs_flat on the edge that loads it into out_data.
//    Latency start->first valid = 1 cycle; throughput 1 word/cycle.
//  ZERO_R0=1: a word loaded for index 0 is forced to 0.
//  out_last = out_valid && (out_idx==end_idx).
//  abort=1 in SEND: next cycle IDLE, out_valid=0, busy=0.
//    No done pulse is issued, and checksum holds the partial sum.
//    abort has priority over a simultaneous transfer; that word is not counted.
//  abort in IDLE: ignored. start while busy: ignored.
//    Simultaneous start+abort in IDLE: start wins.
//  Index arithmetic never wraps: end_idx = NUM_REGS-1 terminates at that index.
// TESTING
//  1 rst=0 for 2 cycles with garbage inputs -> all outputs 0, busy=0.
//  2 After register-file reset, dump 0..31 with out_ready=1 -> 32 consecutive
//    valid cycles; idx2 data=0x7FFFEFFC, all others 0; checksum=0x7FFFEFFC;
//    done at cycle 33 after start.
//  3 Regs i=i*0x11, dump 3..6, out_ready toggling 1,0 -> data 0x33,0x44,0x55,0x66,
//    each held stable while stalled; out_last only on 0x66; checksum=0x132.
//  4 start_idx=9, end_idx=4 -> no out_valid; single done pulse; checksum=0.
//  5 Dump 0..31; abort on the 5th word with out_ready=1 -> that word not counted;
//    no done pulse; checksum = sum of idx0..3. Repeat with rst=0 mid-dump ->
//    all outputs 0 next cycle.
//  6 Regs all 0xFFFFFFFF, ZERO_R0=1, dump 0..2 -> 0,0xFFFFFFFF,0xFFFFFFFF;
//    checksum=0xFFFFFFFE (wrap). Change reg1 while word 1 is stalled -> held word unchanged.

Source files
------------

// File: rtl/reg_dump_reader_if.sv
// Word stream from the register dump reader to its consumer (debug/trace, UART dump).
interface reg_dump_reader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_idx;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks an inclusive index range of the live register file outputs and streams
// each word over valid/ready, ending with a done pulse and a modular checksum.
module reg_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_R0    = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic [ADDR_WIDTH-1:0]                   start_idx_i,
  input  logic [ADDR_WIDTH-1:0]                   end_idx_i,
  input  logic                                    abort_i,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   regs_flat_i,
  reg_dump_reader_if.master                       dump_if,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic [DATA_WIDTH-1:0]                   checksum_o
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] end_idx_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] csum_q;

  logic [DATA_WIDTH-1:0] regs_w [NUM_REGS];
  logic [ADDR_WIDTH-1:0] next_idx_c;
  logic [ADDR_WIDTH-1:0] sample_idx_c;
  logic [DATA_WIDTH-1:0] sample_word_c;
  logic                  xfer_c;

  // Unpack the flat bus; index 0 optionally reads as hard zero.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    if (ZERO_R0 && g == 0) begin : g_zero
      assign regs_w[g] = '0;
    end else begin : g_live
      assign regs_w[g] = regs_flat_i[g*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // next_idx only used while idx_q < end_idx_q, so it cannot wrap.
  assign next_idx_c    = ADDR_WIDTH'(idx_q + 1'b1);
  assign sample_idx_c  = (state_q == IDLE) ? start_idx_i : next_idx_c;
  assign sample_word_c = regs_w[sample_idx_c];
  assign xfer_c        = valid_q & dump_if.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      end_idx_q <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      csum_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            end_idx_q <= end_idx_i;
            csum_q    <= '0;
            if (start_idx_i <= end_idx_i) begin
              state_q <= SEND;
              idx_q   <= start_idx_i;
              data_q  <= sample_word_c;
              valid_q <= 1'b1;
              last_q  <= (start_idx_i == end_idx_i);
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SEND: begin
          // Abort beats a simultaneous transfer; that word is not summed.
          if (abort_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer_c) begin
            csum_q <= csum_q + data_q;
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= next_idx_c;
              data_q <= sample_word_c;
              last_q <= (next_idx_c == end_idx_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump_if.out_valid = valid_q;
  assign dump_if.out_data  = data_q;
  assign dump_if.out_idx   = idx_q;
  assign dump_if.out_last  = last_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign checksum_o        = csum_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: reset, full dump, stalls, empty range,
// abort, mid-dump reset, index-0 forcing and checksum wrap.
module tb_reg_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     start_idx;
  logic [AW-1:0]     end_idx;
  logic              abort;
  logic [NR*DW-1:0]  regs_flat;
  logic              busy;
  logic              done;
  logic [DW-1:0]     checksum;

  int checks = 0;
  int errors = 0;

  reg_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif ();

  reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_R0(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .start_idx_i (start_idx),
    .end_idx_i   (end_idx),
    .abort_i     (abort),
    .regs_flat_i (regs_flat),
    .dump_if     (dif),
    .busy_o      (busy),
    .done_o      (done),
    .checksum_o  (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int i, input logic [DW-1:0] v);
    regs_flat[i*DW +: DW] = v;
  endtask

  task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_idx = s; end_idx = e; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; abort = 1'b1; start_idx = 5'd3; end_idx = 5'd7;
    dif.out_ready = 1'b1; regs_flat = {NR{32'hDEADBEEF}};
    tick(); tick();
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dif.out_valid); end
    checks++; if (dif.out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", dif.out_data); end
    checks++; if (dif.out_idx !== '0) begin errors++; $display("FAIL reset_idx got %h exp 0", dif.out_idx); end
    checks++; if (dif.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", dif.out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum got %h exp 0", checksum); end
    start = 1'b0; abort = 1'b0; rst = 1'b1;
    tick();
  endtask

  // Register-file reset image: x2 holds the initial stack pointer.
  task automatic test_full_dump;
    int bad_valid = 0;
    int bad_data = 0;
    int bad_idx = 0;
    int bad_last = 0;
    regs_flat = '0; set_reg(2, 32'h7FFFEFFC);
    dif.out_ready = 1'b1;
    kick(5'd0, 5'd31);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
    for (int k = 0; k < 32; k++) begin
      if (dif.out_valid !== 1'b1) bad_valid++;
      if (dif.out_idx !== AW'(k)) bad_idx++;
      if (dif.out_data !== ((k == 2) ? 32'h7FFFEFFC : 32'h0)) bad_data++;
      if (dif.out_last !== (k == 31)) bad_last++;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_early_done at word %0d got %b exp 0", k, done); end
      tick();
    end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL full_valid bad cycles %0d exp 0", bad_valid); end
    checks++; if (bad_idx != 0) begin errors++; $display("FAIL full_idx bad cycles %0d exp 0", bad_idx); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL full_data bad cycles %0d exp 0", bad_data); end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL full_last bad cycles %0d exp 0", bad_last); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done_c33 got %b exp 1", done); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_end got %b exp 0", dif.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b exp 0", busy); end
    checks++; if (checksum !== 32'h7FFFEFFC) begin errors++; $display("FAIL full_checksum got %h exp 7fffeffc", checksum); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %b exp 0", done); end
    checks++; if (checksum !== 32'h7FFFEFFC) begin errors++; $display("FAIL full_checksum_hold got %h exp 7fffeffc", checksum); end
  endtask

  task automatic test_stall;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < NR; i++) set_reg(i, DW'(i * 32'h11));
    dif.out_ready = 1'b1;
    kick(5'd3, 5'd6);
    for (int k = 3; k <= 6; k++) begin
      exp_d = DW'(k * 32'h11);
      dif.out_ready = 1'b0;
      checks++; if (dif.out_data !== exp_d || dif.out_idx !== AW'(k)) begin errors++; $display("FAIL stall_word%0d got %h@%0d exp %h@%0d", k, dif.out_data, dif.out_idx, exp_d, k); end
      tick();
      checks++; if (dif.out_valid !== 1'b1 || dif.out_data !== exp_d || dif.out_idx !== AW'(k)) begin errors++; $display("FAIL stall_hold%0d got v%b %h@%0d exp v1 %h@%0d", k, dif.out_valid, dif.out_data, dif.out_idx, exp_d, k); end
      checks++; if (dif.out_last !== (k == 6)) begin errors++; $display("FAIL stall_last%0d got %b exp %b", k, dif.out_last, (k == 6)); end
      dif.out_ready = 1'b1;
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", done); end
    checks++; if (checksum !== 32'h132) begin errors++; $display("FAIL stall_checksum got %h exp 132", checksum); end
  endtask

  task automatic test_empty_range;
    int seen_valid = 0;
    kick(5'd9, 5'd4);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got %b exp 1", done); end
    checks++; if (checksum !== '0) begin errors++; $display("FAIL empty_checksum got %h exp 0", checksum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %b exp 0", busy); end
    if (dif.out_valid !== 1'b0) seen_valid++;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got %b exp 0", done); end
    if (dif.out_valid !== 1'b0) seen_valid++;
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL empty_valid cycles %0d exp 0", seen_valid); end
  endtask

  task automatic test_abort;
    int done_seen = 0;
    dif.out_ready = 1'b1;
    kick(5'd0, 5'd31);
    for (int k = 0; k < 4; k++) tick();
    checks++; if (dif.out_idx !== 5'd4 || dif.out_data !== 32'h44) begin errors++; $display("FAIL abort_5th got %h@%0d exp 44@4", dif.out_data, dif.out_idx); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done !== 1'b0) done_seen++;
    checks++; if (dif.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop got v%b b%b exp v0 b0", dif.out_valid, busy); end
    checks++; if (checksum !== 32'h66) begin errors++; $display("FAIL abort_checksum got %h exp 66", checksum); end
    tick();
    if (done !== 1'b0) done_seen++;
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done pulses %0d exp 0", done_seen); end
    // Abort in IDLE ignored; start+abort together in IDLE starts a dump.
    abort = 1'b1; start_idx = 5'd1; end_idx = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (dif.out_valid !== 1'b1 || dif.out_data !== 32'h11) begin errors++; $display("FAIL start_wins got v%b %h exp v1 11", dif.out_valid, dif.out_data); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_after_start got busy %b exp 0", busy); end
    abort = 1'b0;
    // Synchronous reset mid-dump.
    kick(5'd0, 5'd31);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (dif.out_valid !== 1'b0 || dif.out_data !== '0 || dif.out_idx !== '0 || dif.out_last !== 1'b0) begin errors++; $display("FAIL midrst_out got v%b %h@%0d l%b exp all 0", dif.out_valid, dif.out_data, dif.out_idx, dif.out_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || checksum !== '0) begin errors++; $display("FAIL midrst_status got b%b d%b %h exp 0 0 0", busy, done, checksum); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_r0_wrap;
    regs_flat = {NR{32'hFFFFFFFF}};
    dif.out_ready = 1'b1;
    kick(5'd0, 5'd2);
    checks++; if (dif.out_data !== 32'h0) begin errors++; $display("FAIL r0_zero got %h exp 0", dif.out_data); end
    tick();
    dif.out_ready = 1'b0;
    checks++; if (dif.out_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_w1 got %h exp ffffffff", dif.out_data); end
    set_reg(1, 32'h12345678);
    tick(); tick();
    checks++; if (dif.out_data !== 32'hFFFFFFFF || dif.out_idx !== 5'd1) begin errors++; $display("FAIL held_w1 got %h@%0d exp ffffffff@1", dif.out_data, dif.out_idx); end
    dif.out_ready = 1'b1;
    tick();
    checks++; if (dif.out_data !== 32'hFFFFFFFF || dif.out_last !== 1'b1) begin errors++; $display("FAIL wrap_w2 got %h l%b exp ffffffff l1", dif.out_data, dif.out_last); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", done); end
    checks++; if (checksum !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap_checksum got %h exp fffffffe", checksum); end
  endtask

  initial begin
    dif.out_ready = 1'b0;
    test_reset();
    test_full_dump();
    test_stall();
    test_empty_range();
    test_abort();
    test_zero_r0_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
